u_mcb_rd_check: RTL and testbench

U_MCB_RD_CHECK -- requirements
Module: u_mcb_rd_check

---
 rtl/mcb_test_pkg.sv | 24 ++
 rtl/u_mcb_rd_cmp.sv | 42 ++++
 rtl/u_mcb_rd_check.sv | 101 ++++++++++
 tb/tb_u_mcb_rd_check.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mcb_test_pkg.sv
// Shared constants, state encoding and address helper for the MCB read checker
// and its companion write generator.
package mcb_test_pkg;

    localparam int unsigned  BURST_LEN    = 64;
    localparam logic [29:0]  ADDR_INC     = 30'h400;
    localparam logic [29:0]  END_ADDR     = 30'h1000_0000 - ADDR_INC;
    localparam logic [127:0] SEED_PATTERN = {16{8'hAA}};

    typedef enum logic [1:0] {
        RD_IDLE = 2'd0,
        RD_CMD  = 2'd1,
        RD_DATA = 2'd2,
        RD_NEXT = 2'd3
    } rd_state_t;

    // Next burst base address, wrapping to 0 after the last burst.
    function automatic logic [29:0] next_addr(input logic [29:0] ptr,
                                              input logic [29:0] inc,
                                              input logic [29:0] last);
        return (ptr == last) ? 30'd0 : ptr + inc;
    endfunction

endpackage

// File: rtl/u_mcb_rd_cmp.sv
// Read-data comparator: tracks the alternating AA/55 expected pattern and
// keeps sticky/saturating error accounting from a registered compare.
module u_mcb_rd_cmp
    import mcb_test_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         word_valid,
    input  logic [127:0] word_data,
    input  logic         burst_start,
    output logic         err_flag,
    output logic [15:0]  err_cnt
);

    logic [127:0] expected;
    logic         mismatch;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            expected <= SEED_PATTERN;
            mismatch <= 1'b0;
            err_flag <= 1'b0;
            err_cnt  <= 16'd0;
        end else begin
            mismatch <= word_valid && (word_data != expected);
            if (burst_start) begin
                expected <= SEED_PATTERN;
            end else if (word_valid) begin
                expected <= ~expected;
            end
            // Accounting lags the word by one cycle, so a bad final word is
            // still counted after the FSM has moved on.
            if (mismatch) begin
                err_flag <= 1'b1;
                if (err_cnt != 16'hFFFF) begin
                    err_cnt <= err_cnt + 16'd1;
                end
            end
        end
    end

endmodule

// File: rtl/u_mcb_rd_check.sv
// MCB read-side checker: issues fixed-length read bursts over a wrapping
// address range and verifies the returned AA/55 alternating data.
module u_mcb_rd_check #(
    parameter int unsigned BURST_LEN = mcb_test_pkg::BURST_LEN,
    parameter logic [29:0] ADDR_INC  = mcb_test_pkg::ADDR_INC,
    parameter logic [29:0] END_ADDR  = mcb_test_pkg::END_ADDR
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         rd_start,
    input  logic         u_rd_cmd_done,
    input  logic         u_rd_valid,
    input  logic [127:0] u_rd_data,
    output logic         u_rd_cmd_en,
    output logic         u_rd_en,
    output logic [29:0]  u_rd_addr,
    output logic [6:0]   u_rd_len,
    output logic         err_flag,
    output logic [15:0]  err_cnt,
    output logic [15:0]  burst_cnt
);

    import mcb_test_pkg::rd_state_t;
    import mcb_test_pkg::RD_IDLE;
    import mcb_test_pkg::RD_CMD;
    import mcb_test_pkg::RD_DATA;
    import mcb_test_pkg::RD_NEXT;
    import mcb_test_pkg::next_addr;

    rd_state_t   state;
    rd_state_t   state_next;
    logic [29:0] addr_ptr;
    logic [6:0]  word_cnt;
    logic        word_acc;
    logic        last_word;
    logic        burst_start;

    // Valid words are only meaningful while a burst is being drained.
    assign word_acc    = (state == RD_DATA) && u_rd_valid;
    assign last_word   = word_acc && (word_cnt == 7'(BURST_LEN - 1));
    assign burst_start = (state == RD_IDLE) && rd_start;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RD_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            RD_IDLE: if (rd_start)      state_next = RD_CMD;
            RD_CMD:  if (u_rd_cmd_done) state_next = RD_DATA;
            RD_DATA: if (last_word)     state_next = RD_NEXT;
            RD_NEXT:                    state_next = RD_IDLE;
            default:                    state_next = RD_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            u_rd_cmd_en <= 1'b0;
            u_rd_en     <= 1'b0;
            u_rd_addr   <= 30'd0;
            u_rd_len    <= 7'(BURST_LEN);
            addr_ptr    <= 30'd0;
            word_cnt    <= 7'd0;
            burst_cnt   <= 16'd0;
        end else begin
            // Request stays up until the cycle after the MCB accepts it.
            u_rd_cmd_en <= (state == RD_CMD) && !u_rd_cmd_done;
            u_rd_en     <= (state_next == RD_DATA);
            if (burst_start) begin
                u_rd_addr <= addr_ptr;
                u_rd_len  <= 7'(BURST_LEN);
            end
            if (state == RD_CMD || last_word) begin
                word_cnt <= 7'd0;
            end else if (word_acc) begin
                word_cnt <= word_cnt + 7'd1;
            end
            if (state == RD_NEXT) begin
                burst_cnt <= burst_cnt + 16'd1;
                addr_ptr  <= next_addr(addr_ptr, ADDR_INC, END_ADDR);
            end
        end
    end

    u_mcb_rd_cmp u_cmp (
        .clk         (clk),
        .rst_n       (rst_n),
        .word_valid  (word_acc),
        .word_data   (u_rd_data),
        .burst_start (burst_start),
        .err_flag    (err_flag),
        .err_cnt     (err_cnt)
    );

endmodule

// File: tb/tb_u_mcb_rd_check.sv
// Directed bench for u_mcb_rd_check; END_ADDR shortened to 30'h800 so the
// address wrap is reached after three bursts.
module tb_u_mcb_rd_check;

    localparam logic [127:0] PAT_AA = {16{8'hAA}};
    localparam logic [127:0] PAT_55 = {16{8'h55}};

    logic         clk = 1'b0;
    logic         rst_n;
    logic         rd_start;
    logic         u_rd_cmd_done;
    logic         u_rd_valid;
    logic [127:0] u_rd_data;
    logic         u_rd_cmd_en;
    logic         u_rd_en;
    logic [29:0]  u_rd_addr;
    logic [6:0]   u_rd_len;
    logic         err_flag;
    logic [15:0]  err_cnt;
    logic [15:0]  burst_cnt;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    u_mcb_rd_check #(
        .BURST_LEN (64),
        .ADDR_INC  (30'h400),
        .END_ADDR  (30'h800)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rd_start      (rd_start),
        .u_rd_cmd_done (u_rd_cmd_done),
        .u_rd_valid    (u_rd_valid),
        .u_rd_data     (u_rd_data),
        .u_rd_cmd_en   (u_rd_cmd_en),
        .u_rd_en       (u_rd_en),
        .u_rd_addr     (u_rd_addr),
        .u_rd_len      (u_rd_len),
        .err_flag      (err_flag),
        .err_cnt       (err_cnt),
        .burst_cnt     (burst_cnt)
    );

    // Handshake one burst and feed nwords words (64 = full burst).
    task automatic do_burst(input logic [29:0] exp_addr, input int err_word, input bit gap,
                            input int done_delay, input bit drop_start, input int nwords);
        bit   seen;
        int   n;
        int   cyc;
        logic v;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (u_rd_cmd_en === 1'b1) seen = 1'b1;
        end
        tests++;
        if (!seen) begin
            fails++;
            $display("FAIL cmd_en_timeout: got no u_rd_cmd_en, required one within 20 cycles");
            return;
        end
        tests++;
        if (u_rd_addr !== exp_addr || u_rd_len !== 7'd64) begin
            fails++;
            $display("FAIL burst_addr: got addr=%h len=%0d, required addr=%h len=64", u_rd_addr, u_rd_len, exp_addr);
        end
        repeat (done_delay) @(negedge clk);
        u_rd_cmd_done = 1'b1;
        @(negedge clk);
        u_rd_cmd_done = 1'b0;
        tests++;
        if (u_rd_cmd_en !== 1'b0 || u_rd_en !== 1'b1) begin
            fails++;
            $display("FAIL enter_data: got cmd_en=%b rd_en=%b, required cmd_en=0 rd_en=1", u_rd_cmd_en, u_rd_en);
        end
        n = 0;
        cyc = 0;
        while (n < nwords && cyc < 1000) begin
            v = gap ? 1'($urandom_range(0, 1)) : 1'b1;
            u_rd_valid = v;
            u_rd_data = (n == err_word) ? 128'd0 : ((n % 2 == 1) ? PAT_55 : PAT_AA);
            if (drop_start && n == 20) rd_start = 1'b0;
            @(negedge clk);
            cyc++;
            if (v) begin
                n++;
                if (n == 63) begin
                    tests++;
                    if (u_rd_en !== 1'b1) begin
                        fails++;
                        $display("FAIL early_end: got rd_en=%b after 63 words, required 1", u_rd_en);
                    end
                end
            end
        end
        u_rd_valid = 1'b0;
        u_rd_data = 128'd0;
        tests++;
        if (n != nwords) begin
            fails++;
            $display("FAIL word_timeout: got %0d words sent, required %0d", n, nwords);
        end
        if (nwords == 64) begin
            tests++;
            if (u_rd_en !== 1'b0) begin
                fails++;
                $display("FAIL rd_en_drop: got rd_en=%b after last word, required 0", u_rd_en);
            end
            @(negedge clk);
        end
        $display("[TB] burst addr=%h words=%0d err_word=%0d gap=%0d burst_cnt=%0d err_cnt=%0d",
                 exp_addr, n, err_word, gap, burst_cnt, err_cnt);
    endtask

    task automatic test_reset;
        rst_n = 1'b1;
        rd_start = 1'b0;
        u_rd_cmd_done = 1'b0;
        u_rd_valid = 1'b0;
        u_rd_data = 128'd0;
        #1 rst_n = 1'b0;
        #1;
        tests++;
        if (u_rd_cmd_en !== 1'b0 || u_rd_en !== 1'b0 || u_rd_addr !== 30'd0 || u_rd_len !== 7'd64 ||
            err_flag !== 1'b0 || err_cnt !== 16'd0 || burst_cnt !== 16'd0) begin
            fails++;
            $display("FAIL reset_values: got cmd_en=%b rd_en=%b addr=%h len=%0d ef=%b ec=%0d bc=%0d, required 0 0 0 64 0 0 0",
                     u_rd_cmd_en, u_rd_en, u_rd_addr, u_rd_len, err_flag, err_cnt, burst_cnt);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        tests++;
        if (u_rd_cmd_en !== 1'b0 || burst_cnt !== 16'd0) begin
            fails++;
            $display("FAIL idle_hold: got cmd_en=%b bc=%0d with rd_start=0, required 0 0", u_rd_cmd_en, burst_cnt);
        end
        $display("[TB] reset checked");
    endtask

    task automatic check_counts(input string name, input logic [15:0] exp_bc,
                                input logic [15:0] exp_ec, input logic exp_ef);
        tests++;
        if (burst_cnt !== exp_bc || err_cnt !== exp_ec || err_flag !== exp_ef) begin
            fails++;
            $display("FAIL %s: got bc=%0d ec=%0d ef=%b, required bc=%0d ec=%0d ef=%b",
                     name, burst_cnt, err_cnt, err_flag, exp_bc, exp_ec, exp_ef);
        end
    endtask

    task automatic test_first_burst;
        rd_start = 1'b1;
        do_burst(30'h000, -1, 1'b0, 3, 1'b0, 64);
        check_counts("first_burst", 16'd1, 16'd0, 1'b0);
    endtask

    task automatic test_error_word;
        do_burst(30'h400, 10, 1'b0, 3, 1'b0, 64);
        check_counts("error_word10", 16'd2, 16'd1, 1'b1);
    endtask

    task automatic test_gapped;
        do_burst(30'h800, -1, 1'b1, 0, 1'b0, 64);
        check_counts("gapped_valid", 16'd3, 16'd1, 1'b1);
    endtask

    task automatic test_wrap_last_word;
        do_burst(30'h000, 63, 1'b0, 0, 1'b0, 64);
        check_counts("wrap_last_word_err", 16'd4, 16'd2, 1'b1);
    endtask

    task automatic test_start_drop;
        do_burst(30'h400, -1, 1'b0, 2, 1'b1, 64);
        check_counts("start_drop_burst", 16'd5, 16'd2, 1'b1);
        repeat (10) @(negedge clk);
        tests++;
        if (u_rd_cmd_en !== 1'b0 || burst_cnt !== 16'd5 || u_rd_addr !== 30'h400) begin
            fails++;
            $display("FAIL start_low_idle: got cmd_en=%b bc=%0d addr=%h, required 0 5 400",
                     u_rd_cmd_en, burst_cnt, u_rd_addr);
        end
        rd_start = 1'b1;
    endtask

    task automatic test_reset_mid;
        do_burst(30'h800, -1, 1'b0, 1, 1'b0, 30);
        rst_n = 1'b0;
        #1;
        tests++;
        if (u_rd_cmd_en !== 1'b0 || u_rd_en !== 1'b0 || u_rd_addr !== 30'd0 || u_rd_len !== 7'd64 ||
            err_flag !== 1'b0 || err_cnt !== 16'd0 || burst_cnt !== 16'd0) begin
            fails++;
            $display("FAIL mid_reset: got cmd_en=%b rd_en=%b addr=%h len=%0d ef=%b ec=%0d bc=%0d, required 0 0 0 64 0 0 0",
                     u_rd_cmd_en, u_rd_en, u_rd_addr, u_rd_len, err_flag, err_cnt, burst_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        do_burst(30'h000, -1, 1'b0, 3, 1'b0, 64);
        check_counts("after_mid_reset", 16'd1, 16'd0, 1'b0);
    endtask

    task automatic test_saturation;
        logic [15:0] target;
        int          cyc;
        target = burst_cnt + 16'd1094;
        cyc = 0;
        rd_start = 1'b1;
        u_rd_cmd_done = 1'b1;
        u_rd_valid = 1'b1;
        u_rd_data = 128'd0;
        while (burst_cnt !== target && cyc < 80000) begin
            @(negedge clk);
            cyc++;
        end
        rd_start = 1'b0;
        u_rd_cmd_done = 1'b0;
        u_rd_valid = 1'b0;
        tests++;
        if (burst_cnt !== target) begin
            fails++;
            $display("FAIL sat_timeout: got bc=%0d, required %0d", burst_cnt, target);
        end
        repeat (4) @(negedge clk);
        tests++;
        if (err_cnt !== 16'hFFFF || err_flag !== 1'b1) begin
            fails++;
            $display("FAIL err_saturate: got ec=%h ef=%b, required ffff 1", err_cnt, err_flag);
        end
        $display("[TB] saturation bursts=1094 err_cnt=%h", err_cnt);
    endtask

    initial begin
        test_reset();
        test_first_burst();
        test_error_word();
        test_gapped();
        test_wrap_last_word();
        test_start_drop();
        test_reset_mid();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
